// File: rtl/vdma_frame_scheduler.sv
// Triple-buffered frame scheduler driving a read-DMA core: picks the newest written buffer and hands its address to the core.
// Optional skip_count output is enabled by defining VDMA_FRAME_SCHEDULER_SKIP_CNT_EN.
module vdma_frame_scheduler #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int INDEX_WIDTH     = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       sched_enable,
  input  logic [AXI4_ADDR_WIDTH-1:0] param_base_addr,
  input  logic [AXI4_ADDR_WIDTH-1:0] param_frame_size,
  input  logic                       wr_done,
  input  logic [1:0]                 wr_buf,
  output logic [1:0]                 wr_next_buf,
  output logic [1:0]                 rd_buf,
  output logic                       core_ctl_enable,
  output logic                       core_ctl_update,
  output logic [AXI4_ADDR_WIDTH-1:0] core_param_addr,
  input  logic                       core_ctl_busy,
  input  logic [INDEX_WIDTH-1:0]     core_ctl_index,
  output logic                       sched_busy,
`ifdef VDMA_FRAME_SCHEDULER_SKIP_CNT_EN
  output logic [CNT_WIDTH-1:0]       skip_count,
`endif
  output logic [CNT_WIDTH-1:0]       frame_count
);

  // state    | meaning
  // IDLE     | scheduling stopped, core idle
  // START    | address presented, enable+update pulsed to core
  // WAIT_ACK | holding request until core index moves
  // RUN      | core scanning out rd_buf
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] START    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] RUN      = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]                 state_q;
  logic [1:0]                 state_d;
  logic [1:0]                 latest_q;
  logic [1:0]                 rd_buf_q;
  logic [1:0]                 sel_buf_q;
  logic [INDEX_WIDTH-1:0]     ack_idx_q;
  logic [AXI4_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]       frame_count_q;

  logic                       wr_valid;
  logic [1:0]                 sel_next;
  logic                       start_entry;
  logic                       accept;
  logic [AXI4_ADDR_WIDTH-1:0] addr_next;

  // Buffer 3 does not exist; such completions are dropped.
  assign wr_valid = wr_done && (wr_buf != 2'd3);
  assign sel_next = wr_valid ? wr_buf : latest_q;

  assign start_entry = sched_enable &&
                       ((state_q == IDLE) || ((state_q == RUN) && !core_ctl_busy));
  // Pure inequality so index wrap-around is accepted.
  assign accept = (state_q == WAIT_ACK) && (core_ctl_index != ack_idx_q);

  // sel*size built from shifts; result wraps at the address width.
  always_comb begin
    addr_next = param_base_addr;
    if (sel_next[0]) addr_next = addr_next + param_frame_size;
    if (sel_next[1]) addr_next = addr_next + (param_frame_size << 1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (sched_enable) state_d = START;
      START:    state_d = WAIT_ACK;
      WAIT_ACK: if (accept) state_d = RUN;
      RUN:      if (!core_ctl_busy) state_d = sched_enable ? START : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      latest_q      <= 2'd0;
      rd_buf_q      <= 2'd0;
      sel_buf_q     <= 2'd0;
      ack_idx_q     <= '0;
      addr_q        <= '0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_valid) latest_q <= wr_buf;
      if (start_entry) begin
        sel_buf_q <= sel_next;
        ack_idx_q <= core_ctl_index;
        addr_q    <= addr_next;
      end
      if (accept) begin
        rd_buf_q      <= sel_buf_q;
        frame_count_q <= frame_count_q + CNT_ONE;
      end
    end
  end

`ifdef VDMA_FRAME_SCHEDULER_SKIP_CNT_EN
  logic                 shown_q;
  logic [CNT_WIDTH-1:0] skip_q;

  // The first frame after reset has no predecessor, so it never counts as a repeat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shown_q <= 1'b0;
      skip_q  <= '0;
    end else if (accept) begin
      shown_q <= 1'b1;
      if (shown_q && (sel_buf_q == rd_buf_q) && (skip_q != {CNT_WIDTH{1'b1}}))
        skip_q <= skip_q + CNT_ONE;
    end
  end

  assign skip_count = skip_q;
`endif

  // Writer target: the one buffer neither being shown nor holding the newest frame.
  always_comb begin
    wr_next_buf = 2'd1;
    if (latest_q == rd_buf_q) begin
      case (rd_buf_q)
        2'd0:    wr_next_buf = 2'd1;
        2'd1:    wr_next_buf = 2'd2;
        default: wr_next_buf = 2'd0;
      endcase
    end else begin
      wr_next_buf = 2'd3 - latest_q - rd_buf_q;
    end
  end

  assign rd_buf          = rd_buf_q;
  assign core_ctl_enable = (state_q == START) || (state_q == WAIT_ACK);
  assign core_ctl_update = (state_q == START) || (state_q == WAIT_ACK);
  assign core_param_addr = addr_q;
  assign sched_busy      = (state_q != IDLE);
  assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_vdma_frame_scheduler.sv
// Directed bench for vdma_frame_scheduler; the read-DMA core handshake is driven by hand.
module tb_vdma_frame_scheduler;

  logic        aclk;
  logic        areset;
  logic        sched_enable;
  logic [31:0] param_base_addr;
  logic [31:0] param_frame_size;
  logic        wr_done;
  logic [1:0]  wr_buf;
  logic [1:0]  wr_next_buf;
  logic [1:0]  rd_buf;
  logic        core_ctl_enable;
  logic        core_ctl_update;
  logic [31:0] core_param_addr;
  logic        core_ctl_busy;
  logic [7:0]  core_ctl_index;
  logic        sched_busy;
  logic [15:0] frame_count;
`ifdef VDMA_FRAME_SCHEDULER_SKIP_CNT_EN
  logic [15:0] skip_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  vdma_frame_scheduler dut (
    .aclk             (aclk),
    .areset           (areset),
    .sched_enable     (sched_enable),
    .param_base_addr  (param_base_addr),
    .param_frame_size (param_frame_size),
    .wr_done          (wr_done),
    .wr_buf           (wr_buf),
    .wr_next_buf      (wr_next_buf),
    .rd_buf           (rd_buf),
    .core_ctl_enable  (core_ctl_enable),
    .core_ctl_update  (core_ctl_update),
    .core_param_addr  (core_param_addr),
    .core_ctl_busy    (core_ctl_busy),
    .core_ctl_index   (core_ctl_index),
    .sched_busy       (sched_busy),
`ifdef VDMA_FRAME_SCHEDULER_SKIP_CNT_EN
    .skip_count       (skip_count),
`endif
    .frame_count      (frame_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    32'(core_ctl_enable), 32'd0);
    check({tag, "_upd"},   32'(core_ctl_update), 32'd0);
    check({tag, "_addr"},  core_param_addr, 32'd0);
    check({tag, "_busy"},  32'(sched_busy), 32'd0);
    check({tag, "_wrnxt"}, 32'(wr_next_buf), 32'd1);
    check({tag, "_rdbuf"}, 32'(rd_buf), 32'd0);
    check({tag, "_fcnt"},  32'(frame_count), 32'd0);
`ifdef VDMA_FRAME_SCHEDULER_SKIP_CNT_EN
    check({tag, "_skip"},  32'(skip_count), 32'd0);
`endif
  endtask

  task automatic run_frame();
    core_ctl_busy = 1'b0;
    tick();
    tick();
    core_ctl_index = core_ctl_index + 8'd1;
    core_ctl_busy  = 1'b1;
    tick();
  endtask

  initial begin
    areset           = 1'b0;
    sched_enable     = 1'b0;
    param_base_addr  = 32'h0;
    param_frame_size = 32'h0;
    wr_done          = 1'b0;
    wr_buf           = 2'd0;
    core_ctl_busy    = 1'b0;
    core_ctl_index   = 8'd0;
    #1 areset = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    areset           = 1'b0;
    param_base_addr  = 32'h1000_0000;
    param_frame_size = 32'h0020_0000;
    sched_enable     = 1'b1;

    // First frame from buffer 0
    tick();
    check("f1_start_en",   32'(core_ctl_enable), 32'd1);
    check("f1_start_upd",  32'(core_ctl_update), 32'd1);
    check("f1_start_addr", core_param_addr, 32'h1000_0000);
    check("f1_sbusy",      32'(sched_busy), 32'd1);
    tick();
    tick();
    check("f1_wait_en",    32'(core_ctl_enable), 32'd1);
    check("f1_wait_addr",  core_param_addr, 32'h1000_0000);
    check("f1_wait_fcnt",  32'(frame_count), 32'd0);
    core_ctl_index = 8'd1;
    core_ctl_busy  = 1'b1;
    tick();
    check("f1_run_en",     32'(core_ctl_enable), 32'd0);
    check("f1_run_fcnt",   32'(frame_count), 32'd1);
    check("f1_run_rdbuf",  32'(rd_buf), 32'd0);

    // Writer completes buffer 2 during RUN
    wr_done = 1'b1;
    wr_buf  = 2'd2;
    tick();
    wr_done = 1'b0;
    check("w2_wrnxt", 32'(wr_next_buf), 32'd1);
    core_ctl_busy = 1'b0;
    tick();
    check("f2_start_addr", core_param_addr, 32'h1040_0000);
    tick();
    core_ctl_index = 8'd2;
    core_ctl_busy  = 1'b1;
    tick();
    check("f2_rdbuf", 32'(rd_buf), 32'd2);
    check("f2_wrnxt", 32'(wr_next_buf), 32'd0);
    check("f2_fcnt",  32'(frame_count), 32'd2);

    // wr_done of buffer 1 coincides with START entry
    core_ctl_busy = 1'b0;
    wr_done = 1'b1;
    wr_buf  = 2'd1;
    tick();
    wr_done = 1'b0;
    check("f3_bypass_addr", core_param_addr, 32'h1020_0000);
    tick();
    core_ctl_index = 8'd3;
    core_ctl_busy  = 1'b1;
    tick();
    check("f3_rdbuf", 32'(rd_buf), 32'd1);
    check("f3_wrnxt", 32'(wr_next_buf), 32'd2);

    // wr_buf==3 is ignored; then 2, then a repeat of the buffer on display
    wr_done = 1'b1;
    wr_buf  = 2'd3;
    tick();
    check("w3_ignored_wrnxt", 32'(wr_next_buf), 32'd2);
    wr_buf = 2'd2;
    tick();
    check("w2b_wrnxt", 32'(wr_next_buf), 32'd0);
    wr_buf = 2'd1;
    tick();
    wr_done = 1'b0;
    check("wrep_wrnxt", 32'(wr_next_buf), 32'd2);

    // Index wraps 0xFF -> 0x00
    core_ctl_index = 8'hFF;
    core_ctl_busy  = 1'b0;
    tick();
    check("f4_repeat_addr", core_param_addr, 32'h1020_0000);
    tick();
    tick();
    check("f4_wait_fcnt", 32'(frame_count), 32'd3);
    check("f4_wait_en",   32'(core_ctl_enable), 32'd1);
    core_ctl_index = 8'h00;
    core_ctl_busy  = 1'b1;
    tick();
    check("f4_wrap_fcnt",  32'(frame_count), 32'd4);
    check("f4_wrap_rdbuf", 32'(rd_buf), 32'd1);

    // Disable mid-RUN: frame completes, then IDLE
    sched_enable = 1'b0;
    tick();
    check("dis_run_sbusy", 32'(sched_busy), 32'd1);
    core_ctl_busy = 1'b0;
    tick();
    check("dis_idle_sbusy", 32'(sched_busy), 32'd0);
    check("dis_idle_en",    32'(core_ctl_enable), 32'd0);
    tick();
    check("dis_idle_en2",   32'(core_ctl_enable), 32'd0);
    check("dis_idle_fcnt",  32'(frame_count), 32'd4);

    // Restart, then asynchronous reset in WAIT_ACK
    sched_enable = 1'b1;
    tick();
    check("rs_start_addr", core_param_addr, 32'h1020_0000);
    tick();
    check("rs_wait_en", 32'(core_ctl_enable), 32'd1);
    #2 areset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    areset = 1'b0;

    // Three frames with no writer activity
    run_frame();
    run_frame();
    run_frame();
    check("rep3_fcnt",  32'(frame_count), 32'd3);
    check("rep3_rdbuf", 32'(rd_buf), 32'd0);
    check("rep3_addr",  core_param_addr, 32'h1000_0000);
`ifdef VDMA_FRAME_SCHEDULER_SKIP_CNT_EN
    check("rep3_skip",  32'(skip_count), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
